// File: rtl/logo_bounce_ctrl.sv
// Logo sprite sequencer: bounces a SPRITE x SPRITE logo around the active area once per frame
// and turns the beam position into ROM coordinates plus a registered palette-gated RGB pixel.
module logo_bounce_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SPRITE   = 128,
    parameter int unsigned STEP     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                hpos,
    input  logic [9:0]                vpos,
    input  logic                      display_on,
    input  logic                      pause,
    input  logic                      rom_pixel,
    output logic [$clog2(SPRITE)-1:0] rom_x,
    output logic [$clog2(SPRITE)-1:0] rom_y,
    output logic [5:0]                rgb,
    output logic                      bounce,
    output logic [9:0]                x_pos,
    output logic [9:0]                y_pos
);

    localparam int unsigned RW     = $clog2(SPRITE);
    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - SPRITE);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - SPRITE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [1:0] {StWait, StUpdX, StUpdY, StCommit} state_e;

    state_e     r_state;
    logic       r_tick;
    logic       r_dir_x;  // 1 = moving towards zero
    logic       r_dir_y;
    logic       r_hit;
    logic       r_bounce;
    logic [9:0] r_x_pos;
    logic [9:0] r_y_pos;
    logic [2:0] r_color;
    logic [5:0] r_rgb;

    logic [11:0] w_x_mv;
    logic [11:0] w_y_mv;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_in_sprite;
    logic [5:0]  w_palette;

    // Returns {hit, new_dir, new_pos}; the 11-bit sum keeps pos+STEP from wrapping.
    function automatic logic [11:0] f_move(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] lim);
        logic [10:0] p;
        logic [11:0] res;
        p = {1'b0, pos};
        if (!dir) begin
            if (p + STEP_W >= lim) res = {1'b1, 1'b1, lim[9:0]};
            else                   res = {1'b0, 1'b0, 10'(p + STEP_W)};
        end else begin
            if (p <= STEP_W) res = {1'b1, 1'b0, 10'd0};
            else             res = {1'b0, 1'b1, 10'(p - STEP_W)};
        end
        return res;
    endfunction

    always_comb begin
        w_x_mv      = f_move(r_x_pos, r_dir_x, XMAX);
        w_y_mv      = f_move(r_y_pos, r_dir_y, YMAX);
        w_dx        = hpos - r_x_pos;
        w_dy        = vpos - r_y_pos;
        w_in_sprite = display_on && (w_dx < 10'(SPRITE)) && (w_dy < 10'(SPRITE));
        w_palette   = {{2{r_color[2]}}, {2{r_color[1]}}, {2{r_color[0]}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
            r_rgb  <= 6'h00;
        end else begin
            r_tick <= (vpos == 10'(V_ACTIVE)) && (hpos == 10'd0);
            r_rgb  <= (w_in_sprite && rom_pixel) ? w_palette : 6'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StWait;
            r_x_pos  <= 10'd0;
            r_y_pos  <= 10'd0;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
            r_color  <= 3'd1;
            r_hit    <= 1'b0;
            r_bounce <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            case (r_state)
                StWait: begin
                    if (r_tick && !pause) r_state <= StUpdX;
                end
                StUpdX: begin
                    r_x_pos <= w_x_mv[9:0];
                    r_dir_x <= w_x_mv[10];
                    r_hit   <= r_hit | w_x_mv[11];
                    r_state <= StUpdY;
                end
                StUpdY: begin
                    r_y_pos  <= w_y_mv[9:0];
                    r_dir_y  <= w_y_mv[10];
                    r_hit    <= r_hit | w_y_mv[11];
                    // Registered so the pulse lands exactly on the COMMIT cycle.
                    r_bounce <= r_hit | w_y_mv[11];
                    r_state  <= StCommit;
                end
                StCommit: begin
                    if (r_hit) r_color <= (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;
                    r_hit   <= 1'b0;
                    r_state <= StWait;
                end
                default: r_state <= StWait;
            endcase
        end
    end

    assign rom_x  = w_dx[RW-1:0];
    assign rom_y  = w_dy[RW-1:0];
    assign rgb    = r_rgb;
    assign bounce = r_bounce;
    assign x_pos  = r_x_pos;
    assign y_pos  = r_y_pos;

endmodule

// File: doc/logo_bounce_ctrl.md
# logo_bounce_ctrl

Sequencer for the 128×128 logo bitmap ROM in the VGA screensaver. It keeps the logo's screen position and bounce direction, and moves the logo once per frame during vertical blanking. Each display cycle it converts the beam position into sprite-relative `rom_x`/`rom_y` for the bitmap ROM. It then gates the returned pixel with a bounce-cycled palette colour to produce registered 2-bit-per-channel RGB.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `SPRITE`, 128, sprite edge length in screen pixels (power of two; ROM coordinate width is log2(SPRITE) = 7)
- `STEP`, 1, pixels moved per axis per frame (1..7)

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `hpos`  in  10  beam column from sync generator
- `vpos`  in  10  beam line from sync generator
- `display_on`  in  1  high inside the active area
- `pause`  in  1  high freezes motion (sampled in WAIT)
- `rom_pixel`  in  1  pixel returned by the bitmap ROM (combinational from rom_x/rom_y)
- `rom_x`  out  7  sprite-relative column to ROM
- `rom_y`  out  7  sprite-relative row to ROM
- `rgb`  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- `bounce`  out  1  one-cycle pulse when a wall was hit this frame
- `x_pos`  out  10  sprite left edge
- `y_pos`  out  10  sprite top edge

## Operation
- Limits: XMAX = H_ACTIVE−SPRITE (512), YMAX = V_ACTIVE−SPRITE (352). Invariants: 0 ≤ x_pos ≤ XMAX and 0 ≤ y_pos ≤ YMAX at all times.
- Frame tick: internal one-cycle pulse, registered, asserted on the cycle after (vpos==V_ACTIVE && hpos==0).
- FSM: WAIT → UPD_X → UPD_Y → COMMIT → WAIT.
  - WAIT: leave only on a tick with pause=0. A tick with pause=1 is ignored and the state stays WAIT.
  - UPD_X: moving + and x_pos+STEP ≥ XMAX → x_pos=XMAX, dir_x=−, set hit. Moving − and x_pos ≤ STEP → x_pos=0, dir_x=+, set hit. Otherwise x_pos ± STEP.
  - UPD_Y: same rules using y_pos, dir_y and YMAX.
  - COMMIT: if hit, color advances 1→2→…→7→1 (never 0) and `bounce` pulses for exactly this cycle. hit is then cleared.
  - A corner hit (both axes in the same frame) produces one colour step and one pulse.
- Window: dx = hpos−x_pos, dy = vpos−y_pos (10-bit, unsigned wrap). in_sprite = display_on && dx < SPRITE && dy < SPRITE.
- ROM coordinates: rom_x = dx[6:0], rom_y = dy[6:0], combinational and always driven.
- Palette: color bit2→R, bit1→G, bit0→B. Each set bit drives its channel as 2'b11.
- Output: next rgb = (in_sprite && rom_pixel) ? palette(color) : 6'h00.

## Timing
- Reset (async assert, sync release): state=WAIT, x_pos=0, y_pos=0, dir_x=+, dir_y=+, color=1, hit=0, rgb=0, bounce=0.
- rgb has 1-cycle latency from hpos/vpos. ROM access is combinational within the same cycle.
- Position update completes 4 cycles after the vblank-start condition (tick +1, UPD_X, UPD_Y, COMMIT). x_pos/y_pos change only during vblank, so there is no tearing.
- A tick arriving outside WAIT is dropped. This cannot occur at legal frame timing.
- Reset asserted mid-update (UPD_X..COMMIT) discards the partial update. No bounce pulse is emitted.
- Stability: x_pos, y_pos and color are stable for the entire active region.

## Test plan
- Reset: hold rst_n=0 across clock edges → rgb=0, bounce=0, x_pos=0, y_pos=0. After the first unpaused frame → (1,1).
- Mapping: x_pos=0, y_pos=0, hpos=5, vpos=9, display_on=1 → rom_x=5, rom_y=9. With rom_pixel=1, rgb=6'h03 (color 1 = blue) one cycle later. hpos=128 → rgb=0.
- X bounce: x_pos=511 moving +, y mid-range → next frame x_pos=512, dir_x=−, one bounce pulse, color 1→2. The following frame → x_pos=511.
- Corner: x_pos=511, y_pos=351, both moving + → x=512, y=352, both directions flip, a single bounce pulse, color advances once. Also check the wrap: color 7 → 1 on a bounce.
- Pause: pause=1 across 3 ticks → x_pos, y_pos and color unchanged, no bounce. Release → motion resumes on the next tick.
- Reset mid-update: assert rst_n=0 during UPD_Y → all registers take reset values immediately, no bounce pulse.
